// File: rtl/md_issue.sv
// rtl/md_issue.sv - mult/div issue control: start pulse, D-stage stall, done pulse
// Optional protocol checker enabled by defining MD_ISSUE_CHECK_EN.
module md_issue #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic       e_flush,
  input  logic [3:0] e_op,
  input  logic       d_md_use,
  input  logic       md_busy,
  output logic       md_start,
  output logic [3:0] md_op,
  output logic       stall_d,
  output logic       md_done,
  output logic       proto_err
);

  // opcode encodings shared with the multdiv unit
  localparam logic [3:0] AMULT  = 4'd1;
  localparam logic [3:0] AMULTU = 4'd2;
  localparam logic [3:0] ADIV   = 4'd3;
  localparam logic [3:0] ADIVU  = 4'd4;
  localparam logic [3:0] AMADD  = 4'd5;
  localparam logic [3:0] AMADDU = 4'd6;
  localparam logic [3:0] AMSUB  = 4'd7;
  localparam logic [3:0] AMSUBU = 4'd8;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       done_nxt;
  logic       is_mul;
  logic       is_div;
  logic       issue;

  assign is_mul = (e_op == AMULT) | (e_op == AMULTU) | (e_op == AMADD) |
                  (e_op == AMADDU) | (e_op == AMSUB) | (e_op == AMSUBU);
  assign is_div = (e_op == ADIV) | (e_op == ADIVU);

  // reset gates issue so nothing reaches the multdiv unit while held in reset
  assign issue = reset & e_valid & ~e_flush & (e_op != 4'd0) & (state == IDLE);

  // issue gating, next-state and countdown
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    md_op     = issue ? e_op : 4'd0;
    md_start  = issue & (is_mul | is_div);
    case (state)
      IDLE: begin
        if (md_start) begin
          if (is_div) begin
            state_nxt = DIV_WAIT;
            cnt_nxt   = DIV_CNT;
          end else begin
            state_nxt = MUL_WAIT;
            cnt_nxt   = MUL_CNT;
          end
        end
      end
      MUL_WAIT, DIV_WAIT: begin
        // <= 1 rather than == 1 so a corrupted zero count cannot wrap into a long hang
        if (cnt <= 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // a dependent D instruction waits from the start cycle until the result is back
  assign stall_d = d_md_use & ((state != IDLE) | md_start);

  // state, counter and done pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      md_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      md_done <= done_nxt;
    end
  end

`ifdef MD_ISSUE_CHECK_EN
  logic perr_q;
  logic busy_mismatch;
  logic late_op;

  assign busy_mismatch = md_busy != (state != IDLE);
  assign late_op       = e_valid & ~e_flush & (e_op != 4'd0) & (state != IDLE);

  // sticky flag: set on any busy disagreement or op presented while waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else if (busy_mismatch | late_op) begin
      perr_q <= 1'b1;
    end
  end

  assign proto_err = perr_q;
`else
  logic unused_md_busy;
  assign unused_md_busy = md_busy;
  assign proto_err      = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue.sv
// tb/tb_md_issue.sv - scoreboard bench for md_issue
module tb_md_issue;

  localparam logic [3:0] AMULT  = 4'd1;
  localparam logic [3:0] AMULTU = 4'd2;
  localparam logic [3:0] ADIV   = 4'd3;
  localparam logic [3:0] ADIVU  = 4'd4;
  localparam logic [3:0] AMADD  = 4'd5;
  localparam logic [3:0] AMSUBU = 4'd8;
  localparam logic [3:0] AMTHI  = 4'd9;
  localparam logic [3:0] AMTLO  = 4'd10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic       e_valid;
  logic       e_flush;
  logic [3:0] e_op;
  logic       d_md_use;
  logic       md_busy;
  logic       md_start;
  logic [3:0] md_op;
  logic       stall_d;
  logic       md_done;
  logic       proto_err;

  always #5 clk = ~clk;

  md_issue #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_flush   (e_flush),
    .e_op      (e_op),
    .d_md_use  (d_md_use),
    .md_busy   (md_busy),
    .md_start  (md_start),
    .md_op     (md_op),
    .stall_d   (stall_d),
    .md_done   (md_done),
    .proto_err (proto_err)
  );

  typedef struct {
    logic       start;
    logic [3:0] op;
    logic       stall;
    logic       done;
    logic       perr;
    logic [1:0] st;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // monitor: compares every cycle for which the stimulus queued an expectation
  initial begin
    exp_t       e;
    logic [1:0] act_st;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e      = q.pop_front();
        act_st = dut.state;
        chk("md_start",  {7'd0, md_start},  {7'd0, e.start});
        chk("md_op",     {4'd0, md_op},     {4'd0, e.op});
        chk("stall_d",   {7'd0, stall_d},   {7'd0, e.stall});
        chk("md_done",   {7'd0, md_done},   {7'd0, e.done});
        chk("proto_err", {7'd0, proto_err}, {7'd0, e.perr});
        chk("state",     {6'd0, act_st},    {6'd0, e.st});
        chk("cnt",       {4'd0, dut.cnt},   {4'd0, e.cnt});
      end
    end
  end

  task automatic drive(input logic v, input logic f, input logic [3:0] op,
                       input logic du, input logic b, input logic rs);
    @(posedge clk);
    #1;
    e_valid  = v;
    e_flush  = f;
    e_op     = op;
    d_md_use = du;
    md_busy  = b;
    reset    = rs;
  endtask

  task automatic expect_cycle(input logic s, input logic [3:0] op, input logic sd,
                              input logic dn, input logic pe, input logic [1:0] st,
                              input logic [3:0] c);
    exp_t e;
    e.start = s;
    e.op    = op;
    e.stall = sd;
    e.done  = dn;
    e.perr  = pe;
    e.st    = st;
    e.cnt   = c;
    q.push_back(e);
  endtask

  // reset held low with a valid long op on the E inputs: nothing may issue
  task automatic do_reset();
    drive(1'b1, 1'b0, AMULT, 1'b1, 1'b0, 1'b0);
    expect_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 4'd0);
  endtask

  // one long op; drop_k forces md_busy low in that wait cycle, inj_k presents a stray op
  task automatic long_op(input logic [3:0] op, input int lat, input logic [1:0] wst,
                         input logic du, input int drop_k, input int inj_k);
    logic pe;
    logic b;
    pe = 1'b0;
    drive(1'b1, 1'b0, op, du, 1'b0, 1'b1);
    expect_cycle(1'b1, op, du, 1'b0, pe, S_IDLE, 4'd0);
    for (int k = 1; k <= lat; k++) begin
      b = (k == drop_k) ? 1'b0 : 1'b1;
      if (k == inj_k) drive(1'b1, 1'b0, ADIV, du, b, 1'b1);
      else            drive(1'b0, 1'b0, 4'd0, du, b, 1'b1);
      expect_cycle(1'b0, 4'd0, du, 1'b0, pe, wst, 4'(lat - k + 1));
`ifdef MD_ISSUE_CHECK_EN
      if (k == drop_k || k == inj_k) pe = 1'b1;
`endif
    end
    drive(1'b0, 1'b0, 4'd0, du, 1'b0, 1'b1);
    expect_cycle(1'b0, 4'd0, 1'b0, 1'b1, pe, S_IDLE, 4'd0);
    drive(1'b0, 1'b0, 4'd0, du, 1'b0, 1'b1);
    expect_cycle(1'b0, 4'd0, 1'b0, 1'b0, pe, S_IDLE, 4'd0);
  endtask

  initial begin
    reset    = 1'b0;
    e_valid  = 1'b0;
    e_flush  = 1'b0;
    e_op     = 4'd0;
    d_md_use = 1'b0;
    md_busy  = 1'b0;

    do_reset();
    do_reset();

    // multiply: stall cycles 0..5, done at 6
    long_op(AMULT, 5, S_MUL, 1'b1, 0, 0);
    // divide: stall cycles 0..10, done at 11
    long_op(ADIV, 10, S_DIV, 1'b1, 0, 0);
    // unrelated D instruction never stalls
    long_op(AMSUBU, 5, S_MUL, 1'b0, 0, 0);

    // short ops pass the opcode through without a start pulse or stall
    drive(1'b1, 1'b0, AMTHI, 1'b1, 1'b0, 1'b1);
    expect_cycle(1'b0, AMTHI, 1'b0, 1'b0, 1'b0, S_IDLE, 4'd0);
    drive(1'b1, 1'b0, AMTLO, 1'b1, 1'b0, 1'b1);
    expect_cycle(1'b0, AMTLO, 1'b0, 1'b0, 1'b0, S_IDLE, 4'd0);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    expect_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 4'd0);

    // flushed op issues nothing
    drive(1'b1, 1'b1, AMULTU, 1'b1, 1'b0, 1'b1);
    expect_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 4'd0);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      expect_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 4'd0);
    end

    // divu abandoned by reset at cycle 4
    drive(1'b1, 1'b0, ADIVU, 1'b1, 1'b0, 1'b1);
    expect_cycle(1'b1, ADIVU, 1'b1, 1'b0, 1'b0, S_IDLE, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
      expect_cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, S_DIV, 4'(11 - k));
    end
    drive(1'b1, 1'b0, ADIVU, 1'b1, 1'b1, 1'b0);
    expect_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 4'd0);
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      expect_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 4'd0);
    end

    // busy dropped during MUL_WAIT cycle 2
    long_op(AMULT, 5, S_MUL, 1'b1, 2, 0);
    do_reset();
    // stray op presented while waiting is dropped
    long_op(AMADD, 5, S_MUL, 1'b1, 0, 2);
    do_reset();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 4'd0);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_issue.md
MD_ISSUE -- requirements
Module: md_issue

Interface
REQ-001 SHALL have a parameter MUL_LAT, default 5, giving the multiply-class result latency in cycles after the start cycle.
REQ-002 SHALL have a parameter DIV_LAT, default 10, giving the divide-class result latency in cycles after the start cycle.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 e_valid  input  1  E-stage instruction valid.
REQ-007 e_flush  input  1  E-stage instruction killed this cycle.
REQ-008 e_op  input  4  E-stage mult/div opcode from constant.v (`amult..`amsubu, `amthi, `amtlo); 0 = none.
REQ-009 d_md_use  input  1  D-stage instruction is mfhi/mflo/mthi/mtlo or any mult/div-class op.
REQ-010 md_busy  input  1  busy from multdiv unit.
REQ-011 md_start  output  1  start pulse to multdiv unit.
REQ-012 md_op  output  4  gated opcode to multdiv unit.
REQ-013 stall_d  output  1  freeze D stage and bubble E.
REQ-014 md_done  output  1  registered one-cycle pulse, HI/LO updated.
REQ-015 proto_err  output  1  sticky protocol-mismatch flag.

Function
REQ-016 Long ops are mult, multu, madd, maddu, msub, msubu (MUL class) and div, divu (DIV class); mthi/mtlo are short.
REQ-017 issue = e_valid & ~e_flush & (e_op != 0) & (state == IDLE); the block SHALL be purely combinational from issue to md_start/md_op.
REQ-018 md_op SHALL equal e_op when issue, else 0.
REQ-019 md_start SHALL equal issue & long(e_op); short ops SHALL never assert md_start.
REQ-020 FSM states SHALL be IDLE, MUL_WAIT and DIV_WAIT.
REQ-021 On a clock edge with MUL-class md_start: state SHALL go to MUL_WAIT and cnt SHALL load MUL_LAT.
REQ-022 On a clock edge with DIV-class md_start: state SHALL go to DIV_WAIT and cnt SHALL load DIV_LAT.
REQ-023 In a WAIT state, cnt SHALL decrement on each edge; on the edge where cnt==1, state SHALL go to IDLE, cnt SHALL go to 0 and md_done SHALL assert for the following cycle.
REQ-024 stall_d SHALL equal d_md_use & ((state != IDLE) | md_start).
REQ-025 A long op therefore stalls a dependent D instruction for 1+MUL_LAT or 1+DIV_LAT cycles.
REQ-026 Unrelated D instructions (d_md_use=0) SHALL never stall.
REQ-027 An E op with e_flush=1 SHALL issue nothing: md_op=0, md_start=0, no state change.
REQ-028 e_op != 0 while state != IDLE cannot occur by construction (REQ-024); if it does, it SHALL be dropped (md_op=0) and proto_err SHALL set (when the checker is compiled in).
REQ-029 cnt SHALL be 4 bits wide; MUL_LAT and DIV_LAT SHALL be in 1..15.

Reset
REQ-030 While reset=0: state=IDLE, cnt=0, md_done=0, proto_err=0, asynchronously.
REQ-031 Reset asserted mid-operation SHALL abandon the wait; stall_d SHALL drop immediately, subject only to d_md_use and md_start.
REQ-032 md_start and md_op SHALL be 0 while reset=0, regardless of inputs.

Configuration
REQ-033 Macro MD_ISSUE_CHECK_EN defined: each cycle, if md_busy != (state != IDLE), or if REQ-028 occurs, proto_err SHALL set on the next edge and hold until reset.
REQ-034 Macro MD_ISSUE_CHECK_EN undefined: proto_err SHALL be constant 0 and no checker logic SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-035 Scenario 1: e_op=`amult, e_valid=1 at cycle 0, d_md_use=1 -> md_start=1 at cycle 0; stall_d=1 for cycles 0..5; md_done=1 at cycle 6; stall_d=0 at cycle 6.
REQ-036 Scenario 2: e_op=`adiv at cycle 0, d_md_use=1 -> stall_d=1 for cycles 0..10; md_done at cycle 11; state is DIV_WAIT throughout cycles 1..10.
REQ-037 Scenario 3: e_op=`amthi, d_md_use=1 -> md_op=`amthi, md_start=0, stall_d=0, state stays IDLE.
REQ-038 Scenario 4: e_op=`amultu with e_flush=1 -> md_op=0, md_start=0, no stall, no md_done.
REQ-039 Scenario 5: `adivu issued, reset pulled low at cycle 4 -> state=IDLE and cnt=0 immediately; stall_d=0 with reset high and no new op; no md_done.
REQ-040 Scenario 6 (MD_ISSUE_CHECK_EN): md_busy forced 0 during MUL_WAIT cycle 2 -> proto_err=1 from cycle 3 until reset; same stimulus without the macro -> proto_err stays 0.
